debounce_multi: RTL
===================

Name: debounce_multi

Overview:
- Parametrised multi-channel successor to the single-input debouncer.
- Synchronises NUM_CHANNELS asynchronous inputs (buttons, switches) into i_Clk, filters each one independently, and emits per-channel press and release strobes.
- Sits between board pins and control FSMs, so downstream logic needs no edge detectors of its own.

Parameters:
- NUM_CHANNELS, 4, number of independent input channels (>=1).
- DEBOUNCE_LIMIT, 250000, consecutive cycles a synchronised input must disagree with the filtered state before the state flips (>=2).
- HOLD_LIMIT, 12500000, cycles a channel must stay high after its rising strobe before o_Hold fires (>=1). Used only with LONG_PRESS_EN.

Ports:
- i_Clk  input  1  system clock
- i_Rst_L  input  1  asynchronous active-low reset
- i_Signal  input  NUM_CHANNELS  raw asynchronous inputs, bit n = channel n
- o_DebouncedSignal  output  NUM_CHANNELS  filtered level per channel
- o_Rise  output  NUM_CHANNELS  one-cycle strobe when the filtered level goes 0->1
- o_Fall  output  NUM_CHANNELS  one-cycle strobe when the filtered level goes 1->0
- o_Hold  output  NUM_CHANNELS  one-cycle long-press strobe (tied 0 without LONG_PRESS_EN)

Behaviour:
- Reset is asynchronous, active-low. While i_Rst_L=0:
  - all synchroniser flops, counters and state are 0;
  - o_DebouncedSignal, o_Rise, o_Fall and o_Hold are all 0.
- Release from reset takes effect on the next i_Clk rising edge.
- Synchroniser: two flops per channel (s1 <= i_Signal, s2 <= s1). Only s2 feeds the filter.
- Filter, per channel:
  - Counter width is $clog2(DEBOUNCE_LIMIT).
  - If s2 == state: counter <= 0.
  - If s2 != state and counter < DEBOUNCE_LIMIT-1: counter <= counter+1.
  - If s2 != state and counter == DEBOUNCE_LIMIT-1: state <= s2, counter <= 0.
  - So a flip needs exactly DEBOUNCE_LIMIT consecutive mismatching cycles. Any single matching cycle restarts the count, which rejects bounces shorter than the limit.
- Latency: a clean step on i_Signal reaches o_DebouncedSignal in 2 + DEBOUNCE_LIMIT rising edges, ±1 for input sampling phase.
- o_DebouncedSignal is the registered state itself, with no extra stage.
- Strobes:
  - o_Rise[n] and o_Fall[n] are registered. Each is high for exactly the one cycle in which o_DebouncedSignal[n] shows its new value.
  - Otherwise they are 0. Both are never high together on one channel.
- Channels are fully independent. Simultaneous flips on several channels give simultaneous strobes on each.
- Reset mid-count: the counter is discarded. After release the channel restarts from state 0, so an input held high yields o_Rise after 2 + DEBOUNCE_LIMIT cycles.
- No input pattern can make a counter exceed DEBOUNCE_LIMIT-1 or wrap.

Optional Feature:
- Macro: DEBOUNCE_MULTI_LONG_PRESS_EN.
- Defined:
  - Each channel has a hold counter of width $clog2(HOLD_LIMIT+1). It clears to 0 on reset, and while state is 0 it is held at 0.
  - While state is 1 it increments, saturating at HOLD_LIMIT.
  - o_Hold[n] pulses for one cycle when the hold counter reaches HOLD_LIMIT, i.e. HOLD_LIMIT cycles after the o_Rise[n] cycle. It fires at most once per press.
  - A filtered fall before that point cancels the hold and no o_Hold is generated.
- Undefined:
  - No hold counters are synthesised. o_Hold is constant 0.
  - The port list is unchanged.

Test Plan:
- DEBOUNCE_LIMIT=10, NUM_CHANNELS=4. Reset, then i_Signal=4'b0001 held steady -> o_DebouncedSignal[0] rises 12±1 cycles later. o_Rise[0] is high for that one cycle only; channels 1-3 stay 0.
- Channel 0 bounces high 4 cycles, low 1, high 4, low 1, then holds high -> no output change during the bounces. o_DebouncedSignal[0]=1 only after 10 uninterrupted high cycles past the synchroniser.
- Channel 0 debounced high, then i_Signal[0] toggles 1/0 every 3 cycles and finally rests at 0 -> exactly one o_Fall[0] pulse, 12±1 cycles after the final 0. No o_Rise pulse.
- Channels 1 and 3 driven high on the same edge -> o_Rise=4'b1010 in a single cycle. o_DebouncedSignal=4'b1010.
- Channel 2 high for 7 cycles after sync, then i_Rst_L pulsed low for 1 cycle, input still high -> all outputs 0 during reset. o_Rise[2] appears 12±1 cycles after release, not earlier.
- With DEBOUNCE_MULTI_LONG_PRESS_EN and HOLD_LIMIT=20:
  - Press held 40 cycles -> one o_Hold[0] pulse exactly 20 cycles after o_Rise[0].
  - Press held 15 cycles -> no o_Hold pulse.
  - Without the macro -> o_Hold stays 0.

Source files
------------

// File: rtl/debounce_multi.sv
// Multi-channel debouncer: 2-flop synchroniser, per-channel counter filter, rise/fall strobes.
// Define DEBOUNCE_MULTI_LONG_PRESS_EN to add per-channel long-press (o_Hold) strobes.
module debounce_multi #(
    parameter int unsigned NUM_CHANNELS   = 4,
    parameter int unsigned DEBOUNCE_LIMIT = 250000,
    parameter int unsigned HOLD_LIMIT     = 12500000
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst_L,
    input  logic [NUM_CHANNELS-1:0] i_Signal,
    output logic [NUM_CHANNELS-1:0] o_DebouncedSignal,
    output logic [NUM_CHANNELS-1:0] o_Rise,
    output logic [NUM_CHANNELS-1:0] o_Fall,
    output logic [NUM_CHANNELS-1:0] o_Hold
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_LIMIT - 1);

    if (NUM_CHANNELS < 1) begin : gen_chk_channels
        $error("debounce_multi: NUM_CHANNELS must be at least 1");
    end
    if (DEBOUNCE_LIMIT < 2) begin : gen_chk_limit
        $error("debounce_multi: DEBOUNCE_LIMIT must be at least 2");
    end

    logic [NUM_CHANNELS-1:0] sync1_q, sync2_q;
    logic [NUM_CHANNELS-1:0] state_d, state_q;
    logic [NUM_CHANNELS-1:0] rise_d, rise_q;
    logic [NUM_CHANNELS-1:0] fall_d, fall_q;
    logic [CntW-1:0]         cnt_d [NUM_CHANNELS];
    logic [CntW-1:0]         cnt_q [NUM_CHANNELS];

    // Any matching cycle clears the count, so only an unbroken run of mismatches flips state.
    always_comb begin
        state_d = state_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int n = 0; n < int'(NUM_CHANNELS); n++) begin
            cnt_d[n] = '0;
            if (sync2_q[n] != state_q[n]) begin
                if (cnt_q[n] == CntMax) begin
                    state_d[n] = sync2_q[n];
                    rise_d[n]  = sync2_q[n];
                    fall_d[n]  = ~sync2_q[n];
                end else begin
                    cnt_d[n] = cnt_q[n] + CntW'(1);
                end
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync1_q <= '0;
            sync2_q <= '0;
            state_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int n = 0; n < int'(NUM_CHANNELS); n++) begin
                cnt_q[n] <= '0;
            end
        end else begin
            sync1_q <= i_Signal;
            sync2_q <= sync1_q;
            state_q <= state_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            for (int n = 0; n < int'(NUM_CHANNELS); n++) begin
                cnt_q[n] <= cnt_d[n];
            end
        end
    end

    assign o_DebouncedSignal = state_q;
    assign o_Rise            = rise_q;
    assign o_Fall            = fall_q;

`ifdef DEBOUNCE_MULTI_LONG_PRESS_EN
    localparam int unsigned HoldW = $clog2(HOLD_LIMIT + 1);
    localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_LIMIT);

    if (HOLD_LIMIT < 1) begin : gen_chk_hold
        $error("debounce_multi: HOLD_LIMIT must be at least 1");
    end

    logic [HoldW-1:0]        hold_cnt_d [NUM_CHANNELS];
    logic [HoldW-1:0]        hold_cnt_q [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] hold_d, hold_q;

    // Saturation at HoldMax is what limits o_Hold to one pulse per press.
    always_comb begin
        hold_d = '0;
        for (int n = 0; n < int'(NUM_CHANNELS); n++) begin
            hold_cnt_d[n] = '0;
            if (state_q[n]) begin
                if (hold_cnt_q[n] != HoldMax) begin
                    hold_cnt_d[n] = hold_cnt_q[n] + HoldW'(1);
                    hold_d[n]     = (hold_cnt_d[n] == HoldMax);
                end else begin
                    hold_cnt_d[n] = hold_cnt_q[n];
                end
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            hold_q <= '0;
            for (int n = 0; n < int'(NUM_CHANNELS); n++) begin
                hold_cnt_q[n] <= '0;
            end
        end else begin
            hold_q <= hold_d;
            for (int n = 0; n < int'(NUM_CHANNELS); n++) begin
                hold_cnt_q[n] <= hold_cnt_d[n];
            end
        end
    end

    assign o_Hold = hold_q;
`else
    logic [31:0] unused_hold_limit;
    assign unused_hold_limit = 32'(HOLD_LIMIT);
    assign o_Hold = '0;
`endif

endmodule
